// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite word-addressed SRAM slave with WAIT_STATES wait cycles per OKAY data phase.
// Define AHB_SRAM_ERR_EN to answer out-of-range, oversized or misaligned transfers with a two-cycle ERROR.
module ahb_sram_slave #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresten,
  input  logic        hsel,
  input  logic [31:0] hadddr,
  input  logic [1:0]  htrnas,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hmastlock,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [31:0] addr_q;
  logic [2:0] size_q;
  logic write_q, take, bad, unused;
  logic [3:0] be;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];
  // a new address phase is only taken while this slave is not stalling the bus
  assign take = hsel & hready & htrnas[1] & hreadyout;
`ifdef AHB_SRAM_ERR_EN
  assign bad = (|hadddr[31:AW+2]) | (hsize > 3'd2) | ((hsize == 3'd1) & hadddr[0]) |
               ((hsize == 3'd2) & (|hadddr[1:0]));
`else
  assign bad = 1'b0;
`endif
  assign unused = ^{hburst, hmastlock, hprot, htrnas[0], addr_q[31:AW+2]};
  assign hreadyout = !(state == WAIT || state == ERR1);
  assign hresp = state == ERR1 || state == ERR2;
  assign idx = addr_q[AW+1:2];
  assign hrdata = ((state == WAIT || state == DATA) && !write_q) ? mem[idx] : '0;
  // oversized transfers fall through to a full-word write; half/word ignore low address bits
  assign be = size_q == 3'd0 ? 4'b0001 << addr_q[1:0] :
              size_q == 3'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      WAIT: if (cnt == 4'd0) state_n = DATA; else cnt_n = cnt - 4'd1;
      ERR1: state_n = ERR2;
      default: begin
        state_n = IDLE;
        if (take) begin
          state_n = bad ? ERR1 : (WAIT_STATES > 0 ? WAIT : DATA);
          cnt_n = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
        end
      end
    endcase
  end
  always_ff @(posedge hclk or negedge hresten) begin
    if (!hresten) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      size_q <= '0;
      write_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (take) begin
        addr_q <= hadddr;
        size_q <= hsize;
        write_q <= hwrite;
      end
    end
  end
  always_ff @(posedge hclk)
    if (state == DATA && write_q)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= hwdata[8*i +: 8];
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: two slaves (0 and 2 wait states) on a shared bus, checked against a byte-array model.
// Build with AHB_SRAM_ERR_EN defined to exercise the ERROR response path.
module tb_ahb_sram_slave;
  localparam int DEPTH = 256;
  logic hclk = 0, hresten = 0, hwrite = 0, hmastlock = 0;
  logic [1:0] hsel = '0, htrnas = '0;
  logic [31:0] hadddr = '0, hwdata = '0;
  logic [2:0] hsize = '0, hburst = '0;
  logic [3:0] hprot = '0;
  logic [31:0] rd0, rd1, rd_c, r, w0;
  logic ro0, ro1, rs0, rs1, rdy_c, resp_c;
  int cur = 0, n_chk = 0, n_fail = 0;
  logic [7:0] mb [2][DEPTH*4];

  always #5 hclk = ~hclk;
  assign rd_c = cur != 0 ? rd1 : rd0;
  assign rdy_c = cur != 0 ? ro1 : ro0;
  assign resp_c = cur != 0 ? rs1 : rs0;

  ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u0 (
    .hclk(hclk), .hresten(hresten), .hsel(hsel[0]), .hadddr(hadddr), .htrnas(htrnas),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot),
    .hwdata(hwdata), .hready(ro0), .hrdata(rd0), .hreadyout(ro0), .hresp(rs0));
  ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(2)) u1 (
    .hclk(hclk), .hresten(hresten), .hsel(hsel[1]), .hadddr(hadddr), .htrnas(htrnas),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot),
    .hwdata(hwdata), .hready(ro1), .hrdata(rd1), .hreadyout(ro1), .hresp(rs1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
`ifdef AHB_SRAM_ERR_EN
    return a >= DEPTH * 4 || sz > 3'd2 || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic mwrite(input int d, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int n, base, b;
    n = sz >= 3'd2 ? 4 : (1 << sz);
    base = int'(a % (DEPTH * 4)) & ~(n - 1);
    for (int k = 0; k < n; k++) begin
      b = base + k;
      mb[d][b] = wd[8*(b%4) +: 8];
    end
  endtask

  function automatic logic [31:0] mread(input int d, input logic [31:0] a);
    int base;
    base = int'(a % (DEPTH * 4)) & ~3;
    return {mb[d][base+3], mb[d][base+2], mb[d][base+1], mb[d][base]};
  endfunction

  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int waits, output bit resp);
    cur = d;
    hsel = '0;
    hsel[d] = 1'b1;
    hadddr = a; htrnas = 2'b10; hwrite = wr; hsize = sz;
    @(posedge hclk); #1;
    hsel = '0; htrnas = 2'b00; hwdata = wd; waits = 0;
    while (!rdy_c && waits < 40) begin
      @(posedge hclk); #1;
      waits++;
    end
    rd = rd_c;
    resp = resp_c;
    @(posedge hclk); #1;
  endtask

  task automatic check_xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] wd, output logic [31:0] rd);
    int waits;
    bit resp, e;
    logic [31:0] exp;
    e = is_err(a, sz);
    exp = (wr || e) ? 32'h0 : mread(d, a);
    xfer(d, wr, a, sz, wd, rd, waits, resp);
    chk($sformatf("waits d%0d @%h", d, a), waits, e ? 1 : (d != 0 ? 2 : 0));
    chk($sformatf("hresp d%0d @%h", d, a), resp, e);
    chk($sformatf("hrdata d%0d @%h", d, a), rd, exp);
    if (wr && !e) mwrite(d, a, sz, wd);
  endtask

  initial begin
    #12;
    chk("reset_ready0", ro0, 1); chk("reset_resp0", rs0, 0); chk("reset_rdata0", rd0, 0);
    chk("reset_ready1", ro1, 1); chk("reset_resp1", rs1, 0); chk("reset_rdata1", rd1, 0);
    @(posedge hclk); #1 hresten = 1;
    @(posedge hclk); #1;
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++) check_xfer(d, 1, 32'(w * 4), 3'd2, $urandom, r);
    // pipelined write then read with zero wait states
    cur = 0; hsel = 2'b01; htrnas = 2'b10; hwrite = 1; hsize = 3'd2; hadddr = 32'h10;
    @(posedge hclk); #1;
    chk("pipe_ready_w", ro0, 1);
    hwdata = 32'hDEADBEEF; hwrite = 0;
    @(posedge hclk); #1;
    chk("pipe_ready_r", ro0, 1); chk("pipe_rdata", rd0, 32'hDEADBEEF);
    hsel = '0; htrnas = 2'b00;
    mwrite(0, 32'h10, 3'd2, 32'hDEADBEEF);
    @(posedge hclk); #1;
    // byte lanes
    check_xfer(0, 1, 32'h20, 3'd2, 32'h11223344, r);
    check_xfer(0, 1, 32'h21, 3'd0, 32'h0000AA00, r);
    check_xfer(0, 0, 32'h20, 3'd2, 0, r);
    chk("lane_byte", r, 32'h1122AA44);
    check_xfer(0, 1, 32'h22, 3'd1, 32'hBEEF0000, r);
    check_xfer(0, 0, 32'h20, 3'd2, 0, r);
    chk("lane_half", r, 32'hBEEFAA44);
    // two wait states, IDLE presented during the stall
    cur = 1; hsel = 2'b10; htrnas = 2'b10; hwrite = 0; hsize = 3'd2; hadddr = 32'h30;
    @(posedge hclk); #1;
    chk("ws2_wait1", ro1, 0);
    htrnas = 2'b00;
    @(posedge hclk); #1;
    chk("ws2_wait2", ro1, 0);
    @(posedge hclk); #1;
    chk("ws2_ready", ro1, 1); chk("ws2_rdata", rd1, mread(1, 32'h30));
    @(posedge hclk); #1;
    chk("idle_nowait", ro1, 1); chk("idle_okay", rs1, 0);
    hsel = '0;
    // reset asserted mid-wait drops the pending write
    cur = 1; hsel = 2'b10; htrnas = 2'b10; hwrite = 1; hsize = 3'd2; hadddr = 32'h50;
    @(posedge hclk); #1;
    hwdata = 32'h12345678; hsel = '0; htrnas = 2'b00;
    chk("rst_in_wait", ro1, 0);
    hresten = 0; #1;
    chk("rst_ready", ro1, 1); chk("rst_resp", rs1, 0); chk("rst_rdata", rd1, 0);
    @(posedge hclk); #1 hresten = 1;
    @(posedge hclk); #1;
    check_xfer(1, 0, 32'h50, 3'd2, 0, r);
    // unselected NONSEQ write is ignored
    cur = 0; hsel = '0; htrnas = 2'b10; hwrite = 1; hsize = 3'd2; hadddr = 32'h40;
    w0 = mread(0, 32'h40);
    @(posedge hclk); #1;
    hwdata = 32'hFFFFFFFF; htrnas = 2'b00;
    chk("nosel_ready", ro0, 1); chk("nosel_resp", rs0, 0);
    @(posedge hclk); #1;
    chk("nosel_ready2", ro0, 1);
    check_xfer(0, 0, 32'h40, 3'd2, 0, r);
    chk("nosel_unchanged", r, w0);
`ifdef AHB_SRAM_ERR_EN
    cur = 0; hsel = 2'b01; htrnas = 2'b10; hwrite = 0; hsize = 3'd2; hadddr = 32'h400;
    @(posedge hclk); #1;
    hsel = '0; htrnas = 2'b00;
    chk("err1_ready", ro0, 0); chk("err1_resp", rs0, 1); chk("err1_rdata", rd0, 0);
    @(posedge hclk); #1;
    chk("err2_ready", ro0, 1); chk("err2_resp", rs0, 1); chk("err2_rdata", rd0, 0);
    @(posedge hclk); #1;
    chk("err_done", rs0, 0);
    w0 = mread(0, 32'h0);
    check_xfer(0, 1, 32'h02, 3'd2, 32'hCAFEF00D, r);
    check_xfer(0, 0, 32'h00, 3'd2, 0, r);
    chk("err_no_write", r, w0);
`else
    check_xfer(0, 1, 32'h402, 3'd2, 32'hCAFEF00D, r);
    check_xfer(0, 0, 32'h000, 3'd2, 0, r);
    chk("wrap_align", r, 32'hCAFEF00D);
`endif
    for (int i = 0; i < 400; i++) begin
      int d;
      bit wr;
      logic [2:0] sz;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      sz = $urandom_range(0, 9) == 0 ? 3'd3 : 3'($urandom_range(0, 2));
      a = $urandom_range(0, DEPTH * 8 - 1);
      if ($urandom_range(0, 7) == 0) a[31:28] = 4'($urandom);
      check_xfer(d, wr, a, sz, $urandom, r);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
